// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit
// Requester-side fetch controller for a slow, stall-signalling instruction ROM.
// Owns the PC, presents a word address plus chip-select to the ROM, waits for
// the ROM to drop stall, captures the instruction, and hands it to decode over
// a valid/ready handshake. Redirects (branch/jump) are accepted at any time and
// discard whatever fetch is in flight.
//
// Optional feature: define FETCH_TIMEOUT_EN to build the WAIT-state stall
// timeout counter that drives the sticky fetch_err flag. Without it fetch_err
// is tied low.
//
// Ports:
//   clk, rst      posedge clock, asynchronous active-high reset
//   mem_addr      word address to ROM ({2'b00, pc[31:2]})
//   mem_cs        ROM chip-select (high in REQ and WAIT)
//   mem_stall     ROM stall, high while read data is not ready
//   mem_din       ROM read data
//   redirect_en   load redirect_pc as the new PC this cycle
//   redirect_pc   target byte PC (bits [1:0] forced to 0)
//   if_valid      instruction valid toward decode
//   if_ready      decode accepts the instruction
//   if_inst       fetched instruction
//   if_pc         byte PC of if_inst
//   fetch_err     sticky fetch timeout flag
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned TIMEOUT       = 64
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] mem_addr,
  output logic        mem_cs,
  input  logic        mem_stall,
  input  logic [31:0] mem_din,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc,
  output logic        fetch_err
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] ipc_q, ipc_d;
  logic        valid_q, valid_d;
  logic [3:0]  settle_q, settle_d;

`ifdef FETCH_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);
  logic [15:0] tout_q, tout_d;
  logic        err_q, err_d;
`endif

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    addr_d   = addr_q;
    inst_d   = inst_q;
    ipc_d    = ipc_q;
    valid_d  = valid_q;
    settle_d = settle_q;
`ifdef FETCH_TIMEOUT_EN
    tout_d   = tout_q;
    err_d    = err_q;
`endif

    case (state_q)
      IDLE: begin
        state_d  = REQ;
        settle_d = 4'd0;
      end
      // The ROM's stall may still reflect the previous address here, so it is
      // never looked at; we only count out the settle window.
      REQ: begin
        if (settle_q == SETTLE_LAST) begin
          state_d  = WAIT;
          settle_d = 4'd0;
`ifdef FETCH_TIMEOUT_EN
          tout_d   = 16'd0;
`endif
        end else begin
          settle_d = settle_q + 4'd1;
        end
      end
      WAIT: begin
        if (!mem_stall) begin
          inst_d  = mem_din;
          ipc_d   = pc_q;
          valid_d = 1'b1;
          pc_d    = pc_q + 32'd4;
          state_d = HOLD;
        end
`ifdef FETCH_TIMEOUT_EN
        else begin
          if (tout_q != 16'hFFFF) begin
            tout_d = tout_q + 16'd1;
          end
          if (tout_d >= TIMEOUT_CNT) begin
            err_d = 1'b1;
          end
        end
`endif
      end
      // pc already points at the next word; the address only moves when we
      // re-enter REQ so the ROM sees a stable address until then.
      HOLD: begin
        if (if_ready) begin
          valid_d  = 1'b0;
          addr_d   = {2'b00, pc_q[31:2]};
          state_d  = REQ;
          settle_d = 4'd0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Redirect wins over everything, including a same-cycle capture whose
    // data is dropped (if_inst/if_pc keep their previous contents).
    if (redirect_en) begin
      pc_d     = redirect_pc & ~32'd3;
      addr_d   = {2'b00, redirect_pc[31:2]};
      inst_d   = inst_q;
      ipc_d    = ipc_q;
      valid_d  = 1'b0;
      settle_d = 4'd0;
      state_d  = REQ;
`ifdef FETCH_TIMEOUT_EN
      tout_d   = 16'd0;
      err_d    = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      addr_q   <= {2'b00, RESET_PC[31:2]};
      inst_q   <= 32'd0;
      ipc_q    <= 32'd0;
      valid_q  <= 1'b0;
      settle_q <= 4'd0;
`ifdef FETCH_TIMEOUT_EN
      tout_q   <= 16'd0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      addr_q   <= addr_d;
      inst_q   <= inst_d;
      ipc_q    <= ipc_d;
      valid_q  <= valid_d;
      settle_q <= settle_d;
`ifdef FETCH_TIMEOUT_EN
      tout_q   <= tout_d;
      err_q    <= err_d;
`endif
    end
  end

  assign mem_addr = addr_q;
  assign mem_cs   = (state_q == REQ) || (state_q == WAIT);
  assign if_valid = valid_q;
  assign if_inst  = inst_q;
  assign if_pc    = ipc_q;

`ifdef FETCH_TIMEOUT_EN
  assign fetch_err = err_q;
`else
  assign fetch_err = 1'b0;
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Testbench for inst_fetch_unit: behavioural stall-signalling ROM, scoreboard
// of expected {pc, inst} pairs popped on every decode handshake, plus direct
// checks of reset values, address stability, redirects and the timeout flag.
module tb_inst_fetch_unit;

  logic        clk;
  logic        rst;
  logic [31:0] mem_addr;
  logic        mem_cs;
  logic        mem_stall;
  logic [31:0] mem_din;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic        fetch_err;

  int n_checks = 0;
  int n_fails  = 0;

  logic [63:0] exp_q[$];

  int rom_lat   = 7;
  bit rom_stale = 0;
  bit rom_stuck = 0;

  logic [31:0] held_inst;
  logic [31:0] held_pc;

  inst_fetch_unit #(
    .RESET_PC     (32'h0000_0000),
    .SETTLE_CYCLES(1),
    .TIMEOUT      (64)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_addr   (mem_addr),
    .mem_cs     (mem_cs),
    .mem_stall  (mem_stall),
    .mem_din    (mem_din),
    .redirect_en(redirect_en),
    .redirect_pc(redirect_pc),
    .if_valid   (if_valid),
    .if_ready   (if_ready),
    .if_inst    (if_inst),
    .if_pc      (if_pc),
    .fetch_err  (fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    if (a == 32'd0) return 32'h2001_0005;
    return (a * 32'h9E37_79B9) ^ 32'hA5A5_0000;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fails++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // ROM model: stall stays high for rom_lat posedges after the address changes
  // or chip-select rises; optional stale-low first cycle; optional stuck stall.
  initial begin
    int          age;
    logic [31:0] last_addr;
    logic        last_cs;
    age       = 0;
    last_addr = '0;
    last_cs   = 1'b0;
    mem_stall = 1'b1;
    mem_din   = '0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_addr !== last_addr || (mem_cs && !last_cs)) age = 0;
      else if (age < 1000) age++;
      last_addr = mem_addr;
      last_cs   = mem_cs;
      if (rom_stuck) mem_stall = 1'b1;
      else if (rom_stale && age == 0) mem_stall = 1'b0;
      else mem_stall = (age < rom_lat);
      mem_din = rom_word(mem_addr);
    end
  end

  // Scoreboard: every handshake not overridden by a redirect pops one entry.
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      #4;
      if (!rst && if_valid && if_ready && !redirect_en) begin
        if (exp_q.size() == 0) begin
          checkOutput("sb_unexpected_pc", if_pc, 32'hDEAD_BEEF);
        end else begin
          e = exp_q.pop_front();
          checkOutput("sb_pc", if_pc, e[63:32]);
          checkOutput("sb_inst", if_inst, e[31:0]);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic pushExp(input logic [31:0] pc);
    exp_q.push_back({pc, rom_word({2'b00, pc[31:2]})});
  endtask

  task automatic waitValid(input int budget);
    int n = 0;
    while (!if_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!if_valid) checkOutput("wait_valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic acceptOne();
    @(negedge clk);
    if_ready = 1'b1;
    @(negedge clk);
    if_ready = 1'b0;
  endtask

  // One-cycle redirect; the queue is rebuilt with the fetches expected after it.
  task automatic applyStimulus(input logic [31:0] target);
    @(negedge clk);
    redirect_en = 1'b1;
    redirect_pc = target;
    exp_q.delete();
    @(negedge clk);
    redirect_en = 1'b0;
  endtask

  initial begin
    int n;
    rst         = 1'b1;
    redirect_en = 1'b0;
    redirect_pc = '0;
    if_ready    = 1'b0;
    #2;
    checkOutput("rst_mem_addr", mem_addr, 32'd0);
    checkOutput("rst_mem_cs", {31'd0, mem_cs}, 32'd0);
    checkOutput("rst_if_valid", {31'd0, if_valid}, 32'd0);
    checkOutput("rst_if_inst", if_inst, 32'd0);
    checkOutput("rst_if_pc", if_pc, 32'd0);
    checkOutput("rst_fetch_err", {31'd0, fetch_err}, 32'd0);

    // First fetches after reset release
    pushExp(32'h0);
    pushExp(32'h4);
    pushExp(32'h8);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("req_mem_cs", {31'd0, mem_cs}, 32'd1);
    checkOutput("req_mem_addr", mem_addr, 32'd0);
    waitValid(50);
    checkOutput("first_inst", if_inst, 32'h2001_0005);
    checkOutput("first_pc", if_pc, 32'd0);

    // Decode back-pressure: everything held stable, ROM deselected
    held_inst = if_inst;
    held_pc   = if_pc;
    repeat (10) @(negedge clk);
    checkOutput("hold_inst", if_inst, held_inst);
    checkOutput("hold_pc", if_pc, held_pc);
    checkOutput("hold_valid", {31'd0, if_valid}, 32'd1);
    checkOutput("hold_mem_cs", {31'd0, mem_cs}, 32'd0);
    checkOutput("hold_mem_addr", mem_addr, 32'd0);
    acceptOne();
    checkOutput("next_mem_addr", mem_addr, 32'd1);
    checkOutput("next_mem_cs", {31'd0, mem_cs}, 32'd1);
    waitValid(50);
    checkOutput("second_pc", if_pc, 32'd4);

    // Stale stall-low right after the address change must be ignored
    rom_stale = 1;
    rom_lat   = 3;
    acceptOne();
    checkOutput("stale_no_valid0", {31'd0, if_valid}, 32'd0);
    @(negedge clk);
    checkOutput("stale_no_valid1", {31'd0, if_valid}, 32'd0);
    waitValid(50);
    checkOutput("stale_pc", if_pc, 32'd8);
    rom_stale = 0;
    rom_lat   = 5;
    acceptOne();

    // Redirect mid-WAIT
    repeat (2) @(negedge clk);
    applyStimulus(32'h0000_0023);
    pushExp(32'h20);
    checkOutput("redir_mem_addr", mem_addr, 32'd8);
    checkOutput("redir_valid", {31'd0, if_valid}, 32'd0);
    waitValid(50);
    checkOutput("redir_pc", if_pc, 32'h20);
    acceptOne();

    // Redirect on the capture edge: old data never becomes valid
    n = 0;
    while (!(mem_cs && mem_stall === 1'b0) && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("capture_edge_found", {31'd0, mem_cs & ~mem_stall}, 32'd1);
    redirect_en = 1'b1;
    redirect_pc = 32'h0000_0040;
    exp_q.delete();
    pushExp(32'h40);
    @(negedge clk);
    redirect_en = 1'b0;
    checkOutput("edge_redir_valid", {31'd0, if_valid}, 32'd0);
    checkOutput("edge_redir_addr", mem_addr, 32'd16);
    waitValid(50);
    checkOutput("edge_redir_pc", if_pc, 32'h40);
    acceptOne();

    // PC wrap at the top of the address space
    applyStimulus(32'hFFFF_FFFC);
    pushExp(32'hFFFF_FFFC);
    pushExp(32'h0);
    waitValid(50);
    checkOutput("wrap_pc_top", if_pc, 32'hFFFF_FFFC);
    acceptOne();
    waitValid(50);
    checkOutput("wrap_pc_zero", if_pc, 32'd0);
    acceptOne();
    checkOutput("wrap_mem_addr", mem_addr, 32'd1);

    // Async reset mid-WAIT with a non-zero presented pc
    applyStimulus(32'h0000_0100);
    waitValid(50);
    checkOutput("pre_rst_pc", if_pc, 32'h100);
    applyStimulus(32'h0000_0200);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("arst_mem_addr", mem_addr, 32'd0);
    checkOutput("arst_mem_cs", {31'd0, mem_cs}, 32'd0);
    checkOutput("arst_if_valid", {31'd0, if_valid}, 32'd0);
    checkOutput("arst_if_pc", if_pc, 32'd0);
    checkOutput("arst_if_inst", if_inst, 32'd0);
    exp_q.delete();
    rom_stuck = 1;

    // Stuck stall: timeout flag behaviour
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("tout_req_cs", {31'd0, mem_cs}, 32'd1);
    @(negedge clk);
    repeat (63) @(negedge clk);
    checkOutput("tout_before", {31'd0, fetch_err}, 32'd0);
    @(negedge clk);
`ifdef FETCH_TIMEOUT_EN
    checkOutput("tout_set", {31'd0, fetch_err}, 32'd1);
`else
    checkOutput("tout_set", {31'd0, fetch_err}, 32'd0);
`endif
    repeat (10) @(negedge clk);
`ifdef FETCH_TIMEOUT_EN
    checkOutput("tout_sticky", {31'd0, fetch_err}, 32'd1);
`else
    checkOutput("tout_sticky", {31'd0, fetch_err}, 32'd0);
`endif
    rom_stuck = 0;
    rom_lat   = 2;
    applyStimulus(32'h0000_0080);
    pushExp(32'h80);
    checkOutput("tout_clear", {31'd0, fetch_err}, 32'd0);
    waitValid(50);
    acceptOne();
    @(negedge clk);
    checkOutput("sb_drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
- Requester-side fetch controller for the slow, stall-signalling instruction ROM.
- Owns the PC and drives word address plus chip-select to the ROM.
- Holds the address stable until the ROM drops stall, then captures the instruction and presents it to decode with a valid/ready handshake.
- Accepts branch/jump redirects at any time and discards any in-flight fetch.

Parameters:
RESET_PC, 32'h0000_0000, byte PC loaded on reset (bits [1:0] must be 0)
SETTLE_CYCLES, 1, posedges after an address change during which mem_stall is ignored (legal range 1..15)
TIMEOUT, 64, WAIT-state cycles before fetch_err (used only with FETCH_TIMEOUT_EN)

Ports:
clk  in  1  system clock, posedge
rst  in  1  asynchronous, active-high reset
mem_addr  out  32  word address to ROM = {2'b00, pc[31:2]}
mem_cs  out  1  ROM chip-select
mem_stall  in  1  ROM stall, high while data not ready
mem_din  in  32  ROM read data
redirect_en  in  1  load new PC this cycle
redirect_pc  in  32  target byte PC; bits [1:0] ignored, forced to 0
if_valid  out  1  instruction valid toward decode
if_ready  in  1  decode accepts instruction
if_inst  out  32  fetched instruction
if_pc  out  32  byte PC of if_inst
fetch_err  out  1  sticky fetch timeout flag

Behaviour:
- Reset (async, any time including mid-fetch):
  - pc=RESET_PC, state=IDLE, mem_cs=0, mem_addr={2'b00,RESET_PC[31:2]}.
  - if_valid=0, if_inst=0, if_pc=0, fetch_err=0, settle and timeout counters=0.
- States:
  - IDLE: mem_cs=0. Unconditionally goes to REQ at the first posedge after rst deasserts.
  - REQ: mem_cs=1, mem_addr from pc, held constant. The settle counter counts SETTLE_CYCLES posedges with mem_stall ignored. The ROM's stall may be stale for one cycle after an address change, so stall is never trusted here. Then go to WAIT.
  - WAIT: mem_cs=1, address held. At a posedge with mem_stall=0:
    - if_inst<=mem_din, if_pc<=pc, if_valid<=1.
    - pc<=pc+4, wrapping modulo 2^32 (32'hFFFF_FFFC -> 0).
    - Go to HOLD.
  - HOLD: mem_cs=0, mem_addr unchanged. if_valid=1; if_inst and if_pc are stable until accepted. At a posedge with if_ready=1: if_valid<=0, mem_addr updates to the new pc, go to REQ.
- Address stability: mem_addr changes only on entry to REQ. It never changes in REQ or WAIT except by redirect.
- Redirect (highest priority, any non-reset state, sampled at posedge):
  - pc<=redirect_pc&~3, if_valid<=0, settle counter cleared, state<=REQ.
  - Data arriving in the same cycle (mem_stall=0) is discarded.
  - Redirect together with if_valid&if_ready: the instruction counts as consumed and is not re-presented.
  - Redirect to the current pc still restarts REQ. The ROM sees an unchanged address, which is harmless.
  - Redirect in IDLE (first cycle after reset) overrides RESET_PC.
- Fetch latency: from REQ entry to if_valid = SETTLE_CYCLES + ROM latency + 1 posedge for capture. Throughput is at most one instruction per fetch; there is no prefetch overlap.
- mem_stall is don't-care outside WAIT. mem_din is sampled only on the WAIT capture edge.

Optional Feature:
- FETCH_TIMEOUT_EN defined:
  - A 16-bit counter clears on WAIT entry and increments each WAIT cycle with mem_stall=1.
  - When the count reaches TIMEOUT, fetch_err<=1 (sticky) and the FSM keeps waiting.
  - fetch_err clears only on rst or redirect_en.
- FETCH_TIMEOUT_EN undefined: no counter is built, fetch_err is tied 0, and the port remains present.

Test Plan:
1. Reset release, bench ROM stall-low 7 cycles after a stable address, word 0=32'h2001_0005 -> mem_addr=0, mem_cs=1; if_valid rises with if_inst=32'h2001_0005, if_pc=0; next fetch mem_addr=1, if_pc=4.
2. if_ready held 0 for 10 cycles while if_valid=1 -> if_inst/if_pc stable, mem_cs=0, pc not advanced twice; if_ready=1 -> next REQ at pc+4.
3. Stale stall: bench drives mem_stall=0 in the first cycle after an address change -> no capture. Capture only after a WAIT-state stall-low.
4. redirect_en with redirect_pc=32'h0000_0023 mid-WAIT -> in-flight data dropped, mem_addr=8, next if_pc=32'h20; redirect coinciding with the capture edge -> no if_valid for the old pc.
5. redirect_pc=32'hFFFF_FFFC -> if_pc=32'hFFFF_FFFC, then following if_pc=0; async rst pulse mid-WAIT -> all outputs return to reset values immediately, with no clock edge needed.
6. FETCH_TIMEOUT_EN, TIMEOUT=64, mem_stall stuck 1 -> fetch_err=1 after the 64th stalled WAIT cycle, still 1 later; redirect_en -> fetch_err=0. Without the macro -> fetch_err stays 0.
